// File: rtl/vx_burst_arbiter_pkg.sv
// Shared definitions for the burst arbiter: index-width macro and FSM state type.
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package vx_burst_arbiter_pkg;

    // IDLE: free to pick a new requester; LOCKED: a multi-beat burst is open.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vx_burst_arbiter_obuf.sv
// One-entry registered output stage with full throughput: it accepts a new
// beat in the same cycle the held beat drains downstream.
module vx_burst_arbiter_obuf #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [SEL_WIDTH-1:0]  sel_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic [SEL_WIDTH-1:0]  sel_q;

    // The slot can take a beat when empty or when its content leaves this cycle.
    assign ready_o = !valid_q || ready_i;

    // Load on upstream accept, otherwise drain the slot on downstream accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            sel_q   <= sel_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign sel_o   = sel_q;

endmodule

// File: rtl/vx_burst_arbiter.sv
// Round-robin arbiter that locks onto a requester from its first beat until
// its last beat, so bursts from different requesters never interleave.
module vx_burst_arbiter
    import vx_burst_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int LOG_NUM_REQS = `LOG2UP(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            valid_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQS-1:0]            last_in,
    output logic [NUM_REQS-1:0]            ready_in,
    output logic                           valid_out,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           last_out,
    output logic [LOG_NUM_REQS-1:0]        sel_out,
    input  logic                           ready_out,
    output logic                           locked
);

    localparam logic [LOG_NUM_REQS-1:0] LAST_IDX = LOG_NUM_REQS'(NUM_REQS - 1);
    localparam logic [LOG_NUM_REQS:0]   NUM_EXT  = (LOG_NUM_REQS + 1)'(NUM_REQS);

    // Modulo-NUM_REQS increment; non-power-of-two counts wrap at NUM_REQS-1.
    function automatic logic [LOG_NUM_REQS-1:0] idx_inc(input logic [LOG_NUM_REQS-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    arb_state_e                state_q;
    logic [LOG_NUM_REQS-1:0]   ptr_q;
    logic [LOG_NUM_REQS-1:0]   lock_idx_q;
    logic                      locked_q;

    logic [LOG_NUM_REQS:0]     idx_sum;
    logic [LOG_NUM_REQS-1:0]   pick_idx;
    logic                      pick_valid;
    logic [LOG_NUM_REQS-1:0]   grant_idx;
    logic                      grant_en;
    logic                      can_load;
    logic                      beat_acc;
    logic                      beat_last;
    logic [DATA_WIDTH-1:0]     beat_data;
    logic [DATA_WIDTH-1:0]     data_arr [NUM_REQS];

    // Rotate-then-priority pick: scan ptr, ptr+1, ... and keep the nearest valid.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        idx_sum    = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx_sum = {1'b0, ptr_q} + (LOG_NUM_REQS + 1)'(k);
            if (idx_sum >= NUM_EXT) begin
                idx_sum = idx_sum - NUM_EXT;
            end
            if (valid_in[idx_sum[LOG_NUM_REQS-1:0]]) begin
                pick_idx   = idx_sum[LOG_NUM_REQS-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    // An open burst owns the grant even while its requester is momentarily idle.
    assign grant_idx = (state_q == ARB_LOCKED) ? lock_idx_q : pick_idx;
    assign grant_en  = (state_q == ARB_LOCKED) || pick_valid;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
        assign ready_in[gi] = can_load && grant_en && (grant_idx == LOG_NUM_REQS'(gi));
        assign data_arr[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign beat_acc  = |(valid_in & ready_in);
    assign beat_last = last_in[grant_idx];
    assign beat_data = data_arr[grant_idx];

    // Burst FSM: open a lock on a non-last first beat, advance ptr past the
    // granted requester whenever its last beat is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            locked_q   <= 1'b0;
        end else if (beat_acc) begin
            case (state_q)
                ARB_IDLE: begin
                    if (beat_last) begin
                        ptr_q <= idx_inc(pick_idx);
                    end else begin
                        state_q    <= ARB_LOCKED;
                        lock_idx_q <= pick_idx;
                        locked_q   <= 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    if (beat_last) begin
                        state_q  <= ARB_IDLE;
                        ptr_q    <= idx_inc(lock_idx_q);
                        locked_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign locked = locked_q;

    vx_burst_arbiter_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (LOG_NUM_REQS)
    ) u_obuf (
        .clk     (clk),
        .reset   (reset),
        .valid_i (beat_acc),
        .ready_o (can_load),
        .data_i  (beat_data),
        .last_i  (beat_last),
        .sel_i   (grant_idx),
        .valid_o (valid_out),
        .ready_i (ready_out),
        .data_o  (data_out),
        .last_o  (last_out),
        .sel_o   (sel_out)
    );

endmodule

// File: tb/tb_vx_burst_arbiter.sv
// Randomized bench for vx_burst_arbiter at NUM_REQS=4 and NUM_REQS=3 against a
// transaction-level round-robin/burst-lock reference model.
module tb_vx_burst_arbiter;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // NUM_REQS = 4 instance
    logic [3:0]    v4, l4, r4;
    logic [4*DW-1:0] d4;
    logic          vo4, lo4, ro4, lk4;
    logic [DW-1:0] do4;
    logic [1:0]    so4;

    // NUM_REQS = 3 instance
    logic [2:0]    v3, l3, r3;
    logic [3*DW-1:0] d3;
    logic          vo3, lo3, ro3, lk3;
    logic [DW-1:0] do3;
    logic [1:0]    so3;

    vx_burst_arbiter #(.NUM_REQS(4), .DATA_WIDTH(DW)) u4 (
        .clk(clk), .reset(reset), .valid_in(v4), .data_in(d4), .last_in(l4),
        .ready_in(r4), .valid_out(vo4), .data_out(do4), .last_out(lo4),
        .sel_out(so4), .ready_out(ro4), .locked(lk4)
    );

    vx_burst_arbiter #(.NUM_REQS(3), .DATA_WIDTH(DW)) u3 (
        .clk(clk), .reset(reset), .valid_in(v3), .data_in(d3), .last_in(l3),
        .ready_in(r3), .valid_out(vo3), .data_out(do3), .last_out(lo3),
        .sel_out(so3), .ready_out(ro3), .locked(lk3)
    );

    int total;
    int bad;

    // Reference model state, index 0 = 4-requester DUT, 1 = 3-requester DUT.
    int            m_ptr [2];
    int            m_own [2];
    bit            m_lk  [2];
    bit            m_ov  [2];
    logic [DW-1:0] m_od  [2];
    bit            m_ol  [2];
    int            m_os  [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ptr[u] = 0; m_own[u] = 0; m_lk[u] = 0;
            m_ov[u] = 0; m_od[u] = '0; m_ol[u] = 0; m_os[u] = 0;
        end
    endtask

    // One cycle of the arbiter's rules: who may send, and what the output holds next.
    task automatic model_step(input int u, input int n, input logic [3:0] v, input logic [3:0] l,
                              input logic [4*DW-1:0] d, input logic ro, output logic [3:0] er);
        bit can_load;
        bit found;
        int g;
        can_load = !m_ov[u] || ro;
        found = 0;
        g = 0;
        if (m_lk[u]) begin
            g = m_own[u];
            found = 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (!found && v[(m_ptr[u] + k) % n]) begin
                    g = (m_ptr[u] + k) % n;
                    found = 1;
                end
            end
        end
        er = (can_load && found) ? 4'(1 << g) : 4'b0;
        if (can_load && found && v[g]) begin
            m_ov[u] = 1;
            m_od[u] = d[g*DW +: DW];
            m_ol[u] = l[g];
            m_os[u] = g;
            if (!m_lk[u] && !l[g]) begin
                m_lk[u] = 1;
                m_own[u] = g;
            end else if (l[g]) begin
                m_lk[u] = 0;
                m_ptr[u] = (g + 1) % n;
            end
        end else if (ro) begin
            m_ov[u] = 0;
        end
    endtask

    task automatic check_regs(input string who, input int u, input logic vo, input logic [DW-1:0] dd,
                              input logic lo, input logic [1:0] so, input logic lk);
        check_val({who, ".valid_out"}, 32'(vo), 32'(m_ov[u]));
        check_val({who, ".data_out"},  32'(dd), 32'(m_od[u]));
        check_val({who, ".last_out"},  32'(lo), 32'(m_ol[u]));
        check_val({who, ".sel_out"},   32'(so), 32'(m_os[u]));
        check_val({who, ".locked"},    32'(lk), 32'(m_lk[u]));
    endtask

    // Called at posedge+1 with inputs applied; checks, advances model, clocks.
    task automatic step();
        logic [3:0] er4, er3;
        #3;
        check_regs("u4", 0, vo4, do4, lo4, so4, lk4);
        check_regs("u3", 1, vo3, do3, lo3, so3, lk3);
        model_step(0, 4, v4, l4, d4, ro4, er4);
        model_step(1, 3, {1'b0, v3}, {1'b0, l3}, {8'h0, d3}, ro3, er3);
        check_val("u4.ready_in", 32'(r4), 32'(er4));
        check_val("u3.ready_in", 32'(r3), 32'(er3));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int unsigned pv, input int unsigned pl, input int unsigned pr);
        for (int i = 0; i < 4; i++) begin
            v4[i] = ($urandom_range(99) < pv);
            l4[i] = ($urandom_range(99) < pl);
        end
        for (int i = 0; i < 3; i++) begin
            v3[i] = ($urandom_range(99) < pv);
            l3[i] = ($urandom_range(99) < pl);
        end
        d4  = $urandom;
        d3  = 24'($urandom);
        ro4 = ($urandom_range(99) < pr);
        ro3 = ($urandom_range(99) < pr);
    endtask

    int unsigned ph_v [4] = '{90, 70, 60, 30};
    int unsigned ph_l [4] = '{20, 35, 40, 60};
    int unsigned ph_r [4] = '{100, 80, 40, 70};

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        v4 = '0; l4 = '0; d4 = '0; ro4 = 1'b0;
        v3 = '0; l3 = '0; d3 = '0; ro3 = 1'b0;
        model_reset();

        // Reset values while held in reset
        #1;
        check_regs("rst.u4", 0, vo4, do4, lo4, so4, lk4);
        check_regs("rst.u3", 1, vo3, do3, lo3, so3, lk3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Fairness with single-beat packets from every requester
        for (int i = 0; i < 12; i++) begin
            v4 = 4'hF; l4 = 4'hF; d4 = $urandom; ro4 = 1'b1;
            v3 = 3'h7; l3 = 3'h7; d3 = 24'($urandom); ro3 = 1'b1;
            step();
            check_val("fair.u4.sel", 32'(so4), 32'(i % 4));
            check_val("fair.u4.valid", 32'(vo4), 32'd1);
            check_val("fair.u3.sel", 32'(so3), 32'(i % 3));
            check_val("fair.u3.valid", 32'(vo3), 32'd1);
        end

        // Randomized phases: bursts, stalls, backpressure
        for (int p = 0; p < 4; p++) begin
            repeat (300) begin
                drive_rand(ph_v[p], ph_l[p], ph_r[p]);
                step();
            end
        end

        // Close any open burst, then open one and reset asynchronously mid-burst
        repeat (3) begin
            v4 = 4'hF; l4 = 4'hF; ro4 = 1'b1;
            v3 = 3'h7; l3 = 3'h7; ro3 = 1'b1;
            step();
        end
        v4 = 4'b0010; l4 = 4'b0000; d4 = $urandom;
        v3 = 3'b010;  l3 = 3'b000;  d3 = 24'($urandom);
        step();
        check_val("pre_arst.u4.locked", 32'(lk4), 32'd1);
        check_val("pre_arst.u3.locked", 32'(lk3), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst.u4.valid_out", 32'(vo4), 32'd0);
        check_val("arst.u4.locked", 32'(lk4), 32'd0);
        check_val("arst.u3.valid_out", 32'(vo3), 32'd0);
        check_val("arst.u3.locked", 32'(lk3), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // After release the lowest valid index wins
        v4 = 4'b1100; l4 = 4'hF; d4 = $urandom; ro4 = 1'b1;
        v3 = 3'b110;  l3 = 3'h7; d3 = 24'($urandom); ro3 = 1'b1;
        step();
        check_val("post_arst.u4.sel", 32'(so4), 32'd2);
        check_val("post_arst.u3.sel", 32'(so3), 32'd1);
        v4 = '0; v3 = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
